// File: rtl/arm_imm_encoder.sv
// Finds an ARM data-processing rotated immediate (imm8 ROR 2*rot) or a 12-bit signed memory offset for a 32-bit constant.
// Define IMM_ENCODER_NEGATE_EN to also search ~value (MVN form) after a direct miss.
module arm_imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_Start,
    input  logic [31:0] i_Value,
    input  logic        i_Sig_Memory_Instruction,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Valid,
    output logic [11:0] o_Shift_Operand,
    output logic        o_Invert
);

    typedef enum logic [1:0] {IDLE, SEARCH, SEARCH_INV, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] value_q, value_d;
    logic        mem_q, mem_d;
    logic        valid_q, valid_d;
    logic [11:0] operand_q, operand_d;
    logic        invert_q, invert_d;

    logic [31:0] src;
    logic [31:0] candidate;
    logic [5:0]  sh;
    logic        hit;
    logic        mem_fits;

`ifdef IMM_ENCODER_NEGATE_EN
    assign src = (state_q == SEARCH_INV) ? ~value_q : value_q;
`else
    assign src = value_q;
`endif

    // Rotate left by 2*counter undoes the architectural rotate right.
    assign sh        = {1'b0, cnt_q, 1'b0};
    assign candidate = (src << sh) | (src >> (6'd32 - sh));
    assign hit       = (candidate[31:8] == 24'd0);
    assign mem_fits  = (&value_q[31:11]) | ~(|value_q[31:11]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            value_q   <= 32'd0;
            mem_q     <= 1'b0;
            valid_q   <= 1'b0;
            operand_q <= 12'd0;
            invert_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            mem_q     <= mem_d;
            valid_q   <= valid_d;
            operand_q <= operand_d;
            invert_q  <= invert_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        mem_d     = mem_q;
        valid_d   = valid_q;
        operand_d = operand_q;
        invert_d  = invert_q;
        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    state_d   = SEARCH;
                    cnt_d     = 4'd0;
                    value_d   = i_Value;
                    mem_d     = i_Sig_Memory_Instruction;
                    valid_d   = 1'b0;
                    operand_d = 12'd0;
                    invert_d  = 1'b0;
                end
            end
            SEARCH: begin
                if (mem_q) begin
                    valid_d   = mem_fits;
                    operand_d = mem_fits ? value_q[11:0] : 12'd0;
                    state_d   = DONE;
                end else if (hit) begin
                    valid_d   = 1'b1;
                    operand_d = {cnt_q, candidate[7:0]};
                    state_d   = DONE;
                end else if (cnt_q == 4'd15) begin
`ifdef IMM_ENCODER_NEGATE_EN
                    state_d   = SEARCH_INV;
                    cnt_d     = 4'd0;
`else
                    valid_d   = 1'b0;
                    operand_d = 12'd0;
                    state_d   = DONE;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef IMM_ENCODER_NEGATE_EN
            SEARCH_INV: begin
                if (hit) begin
                    valid_d   = 1'b1;
                    invert_d  = 1'b1;
                    operand_d = {cnt_q, candidate[7:0]};
                    state_d   = DONE;
                end else if (cnt_q == 4'd15) begin
                    valid_d   = 1'b0;
                    operand_d = 12'd0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_Busy          = (state_q == SEARCH) || (state_q == SEARCH_INV);
    assign o_Done          = (state_q == DONE);
    assign o_Valid         = valid_q;
    assign o_Shift_Operand = operand_q;
`ifdef IMM_ENCODER_NEGATE_EN
    assign o_Invert        = invert_q;
`else
    assign o_Invert        = 1'b0;
`endif

endmodule
